// File: rtl/seg7_rx_checker.sv
`default_nettype none
// ============================================================================
// Module   : seg7_rx_checker
// Purpose  : Decodes 7-segment glyphs back to hex values, checks the up-count
//            sequence and counts glyph/sequence errors (saturating).
// Option   : SEG7_RX_FIB_EN enables the registered Fibonacci flag.
// Revision : 1.0
// ============================================================================
module seg7_rx_checker #(
    parameter int ACTIVE_LOW = 1,
    parameter int STEP       = 1,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       seg_in,
    input  logic             sample_en,
    output logic [3:0]       value_out,
    output logic             value_valid,
    output logic             code_error,
    output logic             seq_error,
    output logic             fib_flag,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [3:0] C_STEP = 4'(STEP);

    typedef enum logic [0:0] {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       seg_q, seg_d;
    logic             sample_q, sample_d;
    logic [3:0]       value_q, value_d;
    logic [3:0]       exp_q, exp_d;
    logic [3:0]       last_q, last_d;
    logic             valid_q, valid_d;
    logic             cerr_q, cerr_d;
    logic             serr_q, serr_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             w_legal;
    logic [3:0]       w_val;
    logic             w_err_evt;

    // Samples are held in active-low form so one decode table serves both polarities.
    assign seg_d    = (ACTIVE_LOW != 0) ? seg_in : ~seg_in;
    assign sample_d = sample_en;

    always_comb begin
        w_legal = 1'b1;
        w_val   = 4'h0;
        case (seg_q)
            7'h40: w_val = 4'h0;
            7'h79: w_val = 4'h1;
            7'h24: w_val = 4'h2;
            7'h30: w_val = 4'h3;
            7'h19: w_val = 4'h4;
            7'h12: w_val = 4'h5;
            7'h02: w_val = 4'h6;
            7'h78: w_val = 4'h7;
            7'h00: w_val = 4'h8;
            7'h10: w_val = 4'h9;
            7'h08: w_val = 4'hA;
            7'h03: w_val = 4'hB;
            7'h46: w_val = 4'hC;
            7'h21: w_val = 4'hD;
            7'h06: w_val = 4'hE;
            7'h0E: w_val = 4'hF;
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        value_d   = value_q;
        exp_d     = exp_q;
        last_d    = last_q;
        valid_d   = 1'b0;
        cerr_d    = 1'b0;
        serr_d    = 1'b0;
        w_err_evt = 1'b0;
        if (sample_q) begin
            if (!w_legal) begin
                cerr_d    = 1'b1;
                w_err_evt = 1'b1;
                state_d   = SYNC;
            end else begin
                valid_d = 1'b1;
                value_d = w_val;
                if (state_q == SYNC) begin
                    last_d  = w_val;
                    exp_d   = w_val + C_STEP;
                    state_d = TRACK;
                end else if (w_val == exp_q) begin
                    last_d = w_val;
                    exp_d  = exp_q + C_STEP;
                end else if (w_val != last_q) begin
                    // Resynchronise on the new value rather than staying lost.
                    serr_d    = 1'b1;
                    w_err_evt = 1'b1;
                    last_d    = w_val;
                    exp_d     = w_val + C_STEP;
                end
            end
        end
        err_d = err_q;
        if (w_err_evt && (err_q != {ERR_W{1'b1}}))
            err_d = err_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= SYNC;
            seg_q    <= 7'h0;
            sample_q <= 1'b0;
            value_q  <= 4'h0;
            exp_q    <= 4'h0;
            last_q   <= 4'h0;
            valid_q  <= 1'b0;
            cerr_q   <= 1'b0;
            serr_q   <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            seg_q    <= seg_d;
            sample_q <= sample_d;
            value_q  <= value_d;
            exp_q    <= exp_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
            cerr_q   <= cerr_d;
            serr_q   <= serr_d;
            err_q    <= err_d;
        end
    end

`ifdef SEG7_RX_FIB_EN
    logic fib_q, fib_d;

    always_comb begin
        fib_d = fib_q;
        if (sample_q && w_legal)
            fib_d = (w_val inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd13});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fib_q <= 1'b0;
        else
            fib_q <= fib_d;
    end

    assign fib_flag = fib_q;
`else
    assign fib_flag = 1'b0;
`endif

    assign value_out   = value_q;
    assign value_valid = valid_q;
    assign code_error  = cerr_q;
    assign seq_error   = serr_q;
    assign err_count   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_rx_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_rx_checker
// Purpose  : Directed self-checking bench for seg7_rx_checker (active-low,
//            active-high and ERR_W=2 instances share one stimulus stream).
// Revision : 1.0
// ============================================================================
module tb_seg7_rx_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] seg_in = 7'h7F;
    logic       sample_en = 1'b0;
    logic [6:0] seg_ah;

    logic [3:0] value_out, ah_value;
    logic       value_valid, code_error, seq_error, fib_flag;
    logic       ah_valid, ah_cerr, ah_serr, ah_fib;
    logic       s_valid, s_cerr, s_serr, s_fib;
    logic [3:0] s_value;
    logic [7:0] err_count, ah_err;
    logic [1:0] s_err;

    int n_vec = 0;
    int n_err = 0;
    int exp_err = 0;
    logic [3:0] exp_val = 4'h0;
    logic       exp_fib = 1'b0;
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    assign seg_ah = ~seg_in;

    always #5 clk = ~clk;

    seg7_rx_checker #(.ACTIVE_LOW(1), .STEP(1), .ERR_W(8)) u_dut (
        .clk(clk), .reset(reset), .seg_in(seg_in), .sample_en(sample_en),
        .value_out(value_out), .value_valid(value_valid), .code_error(code_error),
        .seq_error(seq_error), .fib_flag(fib_flag), .err_count(err_count));

    seg7_rx_checker #(.ACTIVE_LOW(0), .STEP(1), .ERR_W(8)) u_ah (
        .clk(clk), .reset(reset), .seg_in(seg_ah), .sample_en(sample_en),
        .value_out(ah_value), .value_valid(ah_valid), .code_error(ah_cerr),
        .seq_error(ah_serr), .fib_flag(ah_fib), .err_count(ah_err));

    seg7_rx_checker #(.ACTIVE_LOW(1), .STEP(1), .ERR_W(2)) u_sat (
        .clk(clk), .reset(reset), .seg_in(seg_in), .sample_en(sample_en),
        .value_out(s_value), .value_valid(s_valid), .code_error(s_cerr),
        .seq_error(s_serr), .fib_flag(s_fib), .err_count(s_err));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic is_fib(input logic [3:0] v);
`ifdef SEG7_RX_FIB_EN
        return v inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd13};
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_outputs(input string tag, input logic vv, input logic ce, input logic se);
        check({tag, ".value"}, 32'(value_out), 32'(exp_val));
        check({tag, ".valid"}, 32'(value_valid), 32'(vv));
        check({tag, ".cerr"},  32'(code_error), 32'(ce));
        check({tag, ".serr"},  32'(seq_error), 32'(se));
        check({tag, ".errcnt"}, 32'(err_count), 32'(exp_err));
        check({tag, ".fib"},   32'(fib_flag), 32'(exp_fib));
        check({tag, ".ah_value"}, 32'(ah_value), 32'(exp_val));
        check({tag, ".ah_errcnt"}, 32'(ah_err), 32'(exp_err));
    endtask

    // Drive one sample at edge N, inspect the result 1 ns after edge N+1.
    task automatic sample(input string tag, input logic [6:0] code, input logic [3:0] v,
                          input logic vv, input logic ce, input logic se);
        @(negedge clk);
        seg_in    = code;
        sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        seg_in    = 7'h7F;
        @(posedge clk);
        #1;
        if (ce) exp_err++;
        if (se) exp_err++;
        if (vv) begin
            exp_val = v;
            exp_fib = is_fib(v);
        end
        check_outputs(tag, vv, ce, se);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        exp_err = 0;
        exp_val = 4'h0;
        exp_fib = 1'b0;
    endtask

    initial begin
        // Reset held for 30 ns while the input keeps changing and sampling.
        reset     = 1'b1;
        sample_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            seg_in = glyph[(i * 5) % 16];
            #5;
        end
        check_outputs("rst", 1'b0, 1'b0, 1'b0);
        check("rst.sat", 32'(s_err), 32'd0);
        @(negedge clk);
        sample_en = 1'b0;
        reset     = 1'b0;

        // Full cycle 0..F then wrap to 0; first sample after reset is a sync.
        for (int i = 0; i < 17; i++)
            sample($sformatf("cyc%0d", i), glyph[i % 16], 4'(i % 16), 1'b1, 1'b0, 1'b0);

        // Held display: repeats are tolerated.
        sample("rep0", 7'h79, 4'h1, 1'b1, 1'b0, 1'b0);
        sample("rep1", 7'h79, 4'h1, 1'b1, 1'b0, 1'b0);
        sample("rep2", 7'h79, 4'h1, 1'b1, 1'b0, 1'b0);
        sample("rep3", 7'h24, 4'h2, 1'b1, 1'b0, 1'b0);

        // Sequence break then resync on the new value.
        do_reset();
        sample("brk0", 7'h40, 4'h0, 1'b1, 1'b0, 1'b0);
        sample("brk1", 7'h79, 4'h1, 1'b1, 1'b0, 1'b0);
        sample("brk2", 7'h30, 4'h3, 1'b1, 1'b0, 1'b1);
        sample("brk3", 7'h19, 4'h4, 1'b1, 1'b0, 1'b0);

        // Illegal glyph: value holds, FSM back to SYNC so a jump is accepted.
        sample("ill0", 7'h7F, 4'h0, 1'b0, 1'b1, 1'b0);
        sample("ill1", 7'h46, 4'hC, 1'b1, 1'b0, 1'b0);
        sample("ill2", 7'h12, 4'h5, 1'b1, 1'b0, 1'b1);

        // Saturation of the 2-bit counter instance.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            sample($sformatf("sat%0d", i), 7'h55, 4'h0, 1'b0, 1'b1, 1'b0);
            check($sformatf("sat%0d.cnt", i), 32'(s_err), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
        end

        // Asynchronous reset mid-stream clears immediately.
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        exp_err = 0;
        exp_val = 4'h0;
        exp_fib = 1'b0;
        check_outputs("arst", 1'b0, 1'b0, 1'b0);
        check("arst.sat", 32'(s_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        sample("post", 7'h02, 4'h6, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
